// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its sequencer:
// mode encodings on the s lines, sequencer state encoding and a mode helper.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } usr_state_e;

    // dir = 0 shifts right, dir = 1 shifts left.
    function automatic logic [1:0] shift_mode(input logic dir);
        return dir ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/usr_bit_counter.sv
// Clear/enable counter with a terminal-count flag raised when the count equals MAX.
// Clear has priority over enable.
module usr_bit_counter #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CW'(MAX));

endmodule

// File: rtl/usr_shift_ctrl.sv
// Sequencer driving a universal shift register: one load cycle, WIDTH shift cycles, done pulse.
// Optional feature macro: USR_CTRL_PAUSE_EN (pause freezes the SHIFT phase).
module usr_shift_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_dir,
    input  logic                       in_fill,
    input  logic                       pause,
    output logic                       in_ready,
    output logic [1:0]                 s,
    output logic [WIDTH-1:0]           din,
    output logic                       sin,
    output logic                       busy,
    output logic                       frame_done,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH + 1);

    usr_state_e       state_q;
    logic [1:0]       s_q;
    logic [WIDTH-1:0] din_q;
    logic             sin_q;
    logic             dir_q;
    logic             fill_q;

    logic             hold;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [CW-1:0]    cnt;

`ifdef USR_CTRL_PAUSE_EN
    assign hold = pause && (state_q == ST_SHIFT);
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold         = 1'b0;
`endif

    // The count is bumped on entry to each shift cycle, so it already reads 1 in the first one.
    assign cnt_en  = (state_q == ST_LOAD) || ((state_q == ST_SHIFT) && !hold && !cnt_tc);
    assign cnt_clr = (state_q == ST_SHIFT) && !hold && cnt_tc;

    usr_bit_counter #(
        .MAX (WIDTH),
        .CW  (CW)
    ) u_bit_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    // Mode and serial lines are registered alongside the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= MODE_HOLD;
            din_q   <= '0;
            sin_q   <= 1'b0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        din_q   <= in_data;
                        dir_q   <= in_dir;
                        fill_q  <= in_fill;
                        s_q     <= MODE_LOAD;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SHIFT;
                    s_q     <= shift_mode(dir_q);
                    sin_q   <= fill_q;
                end
                ST_SHIFT: begin
                    if (hold) begin
                        s_q   <= MODE_HOLD;
                        sin_q <= 1'b0;
                    end else if (cnt_tc) begin
                        state_q <= ST_DONE;
                        s_q     <= MODE_HOLD;
                        sin_q   <= 1'b0;
                    end else begin
                        s_q   <= shift_mode(dir_q);
                        sin_q <= fill_q;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    s_q     <= MODE_HOLD;
                    sin_q   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign s          = s_q;
    assign din        = din_q;
    assign sin        = sin_q;
    assign bit_cnt    = cnt;

endmodule
